// File: rtl/taskwait_multi_if.sv
// ---------------------------------------------------------------------------
// taskwait_multi_if
//   Stream bundle between accelerators and the taskwait tracker.
//   inStream  : two-beat messages from accelerators (header, then task ID).
//   outStream : one-beat wakeup messages (code in TDATA, target in TDEST).
//   Modports:
//     master : the accelerator side (drives inStream, consumes outStream).
//     slave  : the tracker side (consumes inStream, drives outStream).
// ---------------------------------------------------------------------------
interface taskwait_multi_if #(
    parameter int TID_W = 4
);
    logic [63:0]      inStream_TDATA;
    logic             inStream_TVALID;
    logic [TID_W-1:0] inStream_TID;
    logic             inStream_TREADY;

    logic [7:0]       outStream_TDATA;
    logic             outStream_TVALID;
    logic             outStream_TREADY;
    logic [TID_W-1:0] outStream_TDEST;

    modport master (
        output inStream_TDATA, inStream_TVALID, inStream_TID,
        input  inStream_TREADY,
        input  outStream_TDATA, outStream_TVALID, outStream_TDEST,
        output outStream_TREADY
    );

    modport slave (
        input  inStream_TDATA, inStream_TVALID, inStream_TID,
        output inStream_TREADY,
        output outStream_TDATA, outStream_TVALID, outStream_TDEST,
        input  outStream_TREADY
    );
endinterface

// File: rtl/taskwait_multi.sv
// ---------------------------------------------------------------------------
// taskwait_multi
//   Tracks outstanding child tasks per parent task ID. Accelerators send
//   two-beat messages: a header (components in [CMP_W-1:0], type in bit 32,
//   1 = taskwait request, 0 = child-finish) followed by the parent task ID.
//   A register table of TW_ENTRIES entries holds the running count for each
//   parent; when the count reaches zero the waiting accelerator is woken via
//   a WAKE_DEPTH-deep wakeup FIFO. Error wakeups: 8'h02 table full,
//   8'h03 duplicate waiter.
//
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   s              : taskwait_multi_if.slave (inStream / outStream)
//   busy           : FSM not idle or wakeups pending
//   occupancy      : number of valid table entries
//
// Optional feature (macro TW_ERR_STATS_EN):
//   err_full_cnt, err_dup_cnt, drop_cnt : saturating 16-bit event counters.
// ---------------------------------------------------------------------------
module taskwait_multi #(
    parameter int MAX_ACCS   = 16,
    parameter int TW_ENTRIES = 16,
    parameter int CMP_W      = 32,
    parameter int WAKE_DEPTH = 4,
    localparam int TID_W     = ($clog2(MAX_ACCS) > 0) ? $clog2(MAX_ACCS) : 1,
    localparam int IDX_W     = $clog2(TW_ENTRIES),
    localparam int OCC_W     = IDX_W + 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    taskwait_multi_if.slave  s,
    output logic             busy,
    output logic [OCC_W-1:0] occupancy
`ifdef TW_ERR_STATS_EN
    ,
    output logic [15:0]      err_full_cnt,
    output logic [15:0]      err_dup_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int         FP_W      = $clog2(WAKE_DEPTH);
    localparam logic [7:0] CODE_OK   = 8'h01;
    localparam logic [7:0] CODE_FULL = 8'h02;
    localparam logic [7:0] CODE_DUP  = 8'h03;

    typedef enum logic [1:0] {
        READ_HEADER,
        READ_TID,
        SCAN,
        UPDATE
    } state_e;

    state_e state_q, state_d;

    // Message being processed
    logic [CMP_W-1:0] comps_q;
    logic             type_q;
    logic [TID_W-1:0] src_q;
    logic [63:0]      msg_tid_q;

    // Scan bookkeeping
    logic [IDX_W-1:0] idx_q, hit_idx_q, free_idx_q;
    logic             hit_q, free_found_q;

    // Taskwait table
    logic [TW_ENTRIES-1:0] valid_q;
    logic [TW_ENTRIES-1:0] waiter_q;
    logic [TID_W-1:0]      acc_q     [TW_ENTRIES];
    logic [CMP_W-1:0]      cnt_q     [TW_ENTRIES];
    logic [63:0]           tbl_tid_q [TW_ENTRIES];
    logic [OCC_W-1:0]      occ_q;

    // Wakeup FIFO (extra pointer bit distinguishes full from empty)
    logic [FP_W:0]    wr_ptr_q, rd_ptr_q;
    logic [7:0]       fifo_code_q [WAKE_DEPTH];
    logic [TID_W-1:0] fifo_dest_q [WAKE_DEPTH];
    logic             fifo_empty, fifo_full, push, pop;

    // Update decision
    logic [CMP_W-1:0] base, res;
    logic             scan_match, beat;
    logic             want_push, upd_clear, upd_write, upd_drop, upd_fire;
    logic [7:0]       push_code;
    logic [TID_W-1:0] push_dest;
    logic [IDX_W-1:0] wr_idx;

    // Header bits outside components/type carry no meaning here.
    logic unused_hdr;
    assign unused_hdr = ^s.inStream_TDATA;

    assign s.inStream_TREADY = !ap_rst && (state_q == READ_HEADER || state_q == READ_TID);
    assign beat              = s.inStream_TVALID && s.inStream_TREADY;
    assign scan_match        = valid_q[idx_q] && (tbl_tid_q[idx_q] == msg_tid_q);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FP_W] != rd_ptr_q[FP_W]) &&
                        (wr_ptr_q[FP_W-1:0] == rd_ptr_q[FP_W-1:0]);

    assign s.outStream_TVALID = !fifo_empty;
    assign s.outStream_TDATA  = fifo_code_q[rd_ptr_q[FP_W-1:0]];
    assign s.outStream_TDEST  = fifo_dest_q[rd_ptr_q[FP_W-1:0]];
    assign pop                = s.outStream_TVALID && s.outStream_TREADY;

    assign busy      = (state_q != READ_HEADER) || !fifo_empty;
    assign occupancy = occ_q;

    // Update rules and next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        want_push = 1'b0;
        upd_clear = 1'b0;
        upd_write = 1'b0;
        upd_drop  = 1'b0;
        push_code = CODE_OK;
        push_dest = src_q;
        wr_idx    = hit_q ? hit_idx_q : free_idx_q;
        base      = hit_q ? cnt_q[hit_idx_q] : '0;
        res       = type_q ? (base - comps_q) : (base + CMP_W'(1));

        if (hit_q && type_q && waiter_q[hit_idx_q]) begin
            // A second waiter on the same parent: reject, keep the entry.
            want_push = 1'b1;
            push_code = CODE_DUP;
        end else if (res == '0) begin
            want_push = 1'b1;
            upd_clear = hit_q;
            // A finishing child wakes whoever registered the wait.
            if (!type_q) push_dest = acc_q[hit_idx_q];
        end else if (hit_q || free_found_q) begin
            upd_write = 1'b1;
        end else if (type_q) begin
            want_push = 1'b1;
            push_code = CODE_FULL;
        end else begin
            upd_drop = 1'b1;
        end

        // Full FIFO stalls UPDATE unless a pop frees the slot this cycle.
        upd_fire = (state_q == UPDATE) && (!want_push || !fifo_full || pop);
        push     = upd_fire && want_push;

        case (state_q)
            READ_HEADER: if (beat) state_d = READ_TID;
            READ_TID:    if (beat) state_d = SCAN;
            SCAN:        if (scan_match || idx_q == IDX_W'(TW_ENTRIES - 1)) state_d = UPDATE;
            UPDATE:      if (upd_fire) state_d = READ_HEADER;
            default:     state_d = READ_HEADER;
        endcase
    end

    // Control state, message capture, scan progress and table valid bits.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register sees pre-edge values of the others.
            state_q      <= READ_HEADER;
            valid_q      <= '0;
            occ_q        <= '0;
            hit_q        <= 1'b0;
            free_found_q <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                READ_HEADER: begin
                    if (beat) begin
                        comps_q <= s.inStream_TDATA[CMP_W-1:0];
                        type_q  <= s.inStream_TDATA[32];
                        src_q   <= s.inStream_TID;
                    end
                end
                READ_TID: begin
                    if (beat) begin
                        msg_tid_q    <= s.inStream_TDATA;
                        idx_q        <= '0;
                        hit_q        <= 1'b0;
                        free_found_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_match) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= idx_q;
                    end else begin
                        if (!valid_q[idx_q] && !free_found_q) begin
                            free_found_q <= 1'b1;
                            free_idx_q   <= idx_q;
                        end
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                UPDATE: begin
                    if (upd_fire && upd_clear) begin
                        valid_q[wr_idx] <= 1'b0;
                        occ_q           <= occ_q - OCC_W'(1);
                    end else if (upd_fire && upd_write) begin
                        valid_q[wr_idx] <= 1'b1;
                        if (!hit_q) occ_q <= occ_q + OCC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Table payload.
    // NOTE: payload arrays carry no reset; valid_q alone decides whether an
    // entry's contents are ever looked at.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst && upd_fire && upd_write) begin
            cnt_q[wr_idx]     <= res;
            tbl_tid_q[wr_idx] <= msg_tid_q;
            if (type_q) begin
                waiter_q[wr_idx] <= 1'b1;
                acc_q[wr_idx]    <= src_q;
            end else if (!hit_q) begin
                waiter_q[wr_idx] <= 1'b0;
            end
        end
    end

    // Wakeup FIFO pointers and storage.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (FP_W+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (FP_W+1)'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) begin
            fifo_code_q[wr_ptr_q[FP_W-1:0]] <= push_code;
            fifo_dest_q[wr_ptr_q[FP_W-1:0]] <= push_dest;
        end
    end

`ifdef TW_ERR_STATS_EN
    logic [15:0] err_full_q, err_dup_q, drop_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err_full_q <= '0;
            err_dup_q  <= '0;
            drop_q     <= '0;
        end else begin
            if (push && push_code == CODE_FULL && err_full_q != 16'hFFFF) err_full_q <= err_full_q + 16'd1;
            if (push && push_code == CODE_DUP && err_dup_q != 16'hFFFF)   err_dup_q  <= err_dup_q + 16'd1;
            if (upd_fire && upd_drop && drop_q != 16'hFFFF)               drop_q     <= drop_q + 16'd1;
        end
    end

    assign err_full_cnt = err_full_q;
    assign err_dup_cnt  = err_dup_q;
    assign drop_cnt     = drop_q;
`endif

endmodule

// File: tb/tb_taskwait_multi.sv
// ---------------------------------------------------------------------------
// tb_taskwait_multi
//   Directed bench for taskwait_multi (16 accelerators, 16 entries,
//   32-bit counters, 4-deep wakeup FIFO). Each scenario task drives its own
//   messages and compares outputs against hand-computed values.
//   Define TW_ERR_STATS_EN to also connect and check the error counters.
// ---------------------------------------------------------------------------
module tb_taskwait_multi;
    localparam int TID_W = 4;

    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b1;
    logic       busy;
    logic [4:0] occupancy;
    int         checks = 0;
    int         errors = 0;

    taskwait_multi_if #(.TID_W(TID_W)) bus ();

`ifdef TW_ERR_STATS_EN
    logic [15:0] err_full_cnt, err_dup_cnt, drop_cnt;
`endif

    taskwait_multi #(
        .MAX_ACCS(16), .TW_ENTRIES(16), .CMP_W(32), .WAKE_DEPTH(4)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .s(bus.slave),
        .busy(busy),
        .occupancy(occupancy)
`ifdef TW_ERR_STATS_EN
        ,
        .err_full_cnt(err_full_cnt),
        .err_dup_cnt(err_dup_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [63:0] hdr(input logic typ, input logic [31:0] comps);
        return {31'd0, typ, comps};
    endfunction

    // Present one beat and hold it until accepted; returns just after the edge.
    task automatic send_beat(input logic [63:0] data, input logic [TID_W-1:0] tid);
        int n = 0;
        @(negedge ap_clk);
        bus.inStream_TDATA  = data;
        bus.inStream_TID    = tid;
        bus.inStream_TVALID = 1'b1;
        while (!bus.inStream_TREADY) begin
            if (n == 200) begin
                $display("FAIL send_beat: TREADY low for %0d cycles", n);
                $fatal(1);
            end
            @(negedge ap_clk);
            n++;
        end
        @(posedge ap_clk);
        #1;
        bus.inStream_TVALID = 1'b0;
    endtask

    task automatic send_msg(input logic typ, input logic [31:0] comps,
                            input logic [63:0] id, input logic [TID_W-1:0] tid);
        send_beat(hdr(typ, comps), tid);
        send_beat(id, tid);
    endtask

    // Wait until the DUT is back to accepting headers.
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge ap_clk);
            n++;
            if (n == 200) begin
                $display("FAIL wait_idle: TREADY low for %0d cycles", n);
                $fatal(1);
            end
        end while (!bus.inStream_TREADY);
    endtask

    // Wait (bounded) for a wakeup, capture it, and accept it.
    // lat counts falling edges from the call until TVALID is seen.
    task automatic pop_wake(output logic got, output logic [7:0] code,
                            output logic [TID_W-1:0] dest, output int lat);
        lat = 0;
        while (!bus.outStream_TVALID && lat < 100) begin
            @(negedge ap_clk);
            lat++;
        end
        got  = bus.outStream_TVALID;
        code = bus.outStream_TDATA;
        dest = bus.outStream_TDEST;
        if (got) begin
            bus.outStream_TREADY = 1'b1;
            @(posedge ap_clk);
            #1;
            bus.outStream_TREADY = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        bus.inStream_TVALID  = 1'b0;
        bus.outStream_TREADY = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        bus.inStream_TVALID  = 1'b0;
        bus.outStream_TREADY = 1'b0;
        repeat (2) @(negedge ap_clk);
        checks++; if (bus.inStream_TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", bus.inStream_TREADY); end
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", bus.outStream_TVALID); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++; if (bus.inStream_TREADY !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", bus.inStream_TREADY); end
    endtask

    // Wait for 2 children, then both finish: one wake on the second finish.
    task automatic test_taskwait_then_finish();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        send_msg(1'b1, 32'd2, 64'hA, 4'd3);
        wait_idle();
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL a_wait_no_wake: got %b want 0", bus.outStream_TVALID); end
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL a_wait_occupancy: got %0d want 1", occupancy); end
        send_msg(1'b0, 32'd0, 64'hA, 4'd0);
        wait_idle();
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL a_first_no_wake: got %b want 0", bus.outStream_TVALID); end
        send_msg(1'b0, 32'd0, 64'hA, 4'd0);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL a_wake_seen: got %b want 1", got); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL a_wake_code: got %h want 01", code); end
        checks++; if (dest !== 4'd3) begin errors++; $display("FAIL a_wake_dest: got %0d want 3", dest); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL a_hit_latency: got %0d want 3", lat); end
        @(negedge ap_clk);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL a_end_occupancy: got %0d want 0", occupancy); end
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL a_single_wake: got %b want 0", bus.outStream_TVALID); end
    endtask

    // Children finish before the parent waits: wake immediately on the wait.
    task automatic test_finish_first();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        send_msg(1'b0, 32'd0, 64'hB, 4'd0);
        wait_idle();
        send_msg(1'b0, 32'd0, 64'hB, 4'd0);
        wait_idle();
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL b_occupancy: got %0d want 1", occupancy); end
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL b_no_wake: got %b want 0", bus.outStream_TVALID); end
        send_msg(1'b1, 32'd2, 64'hB, 4'd5);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b_wake_seen: got %b want 1", got); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL b_wake_code: got %h want 01", code); end
        checks++; if (dest !== 4'd5) begin errors++; $display("FAIL b_wake_dest: got %0d want 5", dest); end
        @(negedge ap_clk);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL b_invalidated: got %0d want 0", occupancy); end
    endtask

    // Wait with zero children on an unknown ID: immediate wake after full miss scan.
    task automatic test_zero_comps();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        send_msg(1'b1, 32'd0, 64'hC, 4'd1);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL c_wake_seen: got %b want 1", got); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL c_wake_code: got %h want 01", code); end
        checks++; if (dest !== 4'd1) begin errors++; $display("FAIL c_wake_dest: got %0d want 1", dest); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL c_miss_latency: got %0d want 18", lat); end
        @(negedge ap_clk);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL c_occupancy: got %0d want 0", occupancy); end
    endtask

    // Fill the table, then a new waiter gets 8'h02 and a new child is dropped.
    task automatic test_table_full();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        for (int i = 0; i < 16; i++) begin
            send_msg(1'b0, 32'd0, 64'h100 + 64'(i), 4'(i));
            wait_idle();
        end
        checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL d_full_occupancy: got %0d want 16", occupancy); end
        send_msg(1'b1, 32'd4, 64'h99, 4'd2);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL d_full_wake_seen: got %b want 1", got); end
        checks++; if (code !== 8'h02) begin errors++; $display("FAIL d_full_code: got %h want 02", code); end
        checks++; if (dest !== 4'd2) begin errors++; $display("FAIL d_full_dest: got %0d want 2", dest); end
        send_msg(1'b0, 32'd0, 64'h98, 4'd0);
        wait_idle();
        @(negedge ap_clk);
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL d_drop_no_wake: got %b want 0", bus.outStream_TVALID); end
        checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL d_drop_occupancy: got %0d want 16", occupancy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d_idle_busy: got %b want 0", busy); end
`ifdef TW_ERR_STATS_EN
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL d_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (err_full_cnt !== 16'd1) begin errors++; $display("FAIL d_err_full_cnt: got %0d want 1", err_full_cnt); end
`endif
        apply_reset();
    endtask

    // Second waiter on the same parent gets 8'h03; original waiter kept.
    task automatic test_duplicate();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        send_msg(1'b1, 32'd3, 64'hD, 4'd4);
        wait_idle();
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL e_first_no_wake: got %b want 0", bus.outStream_TVALID); end
        send_msg(1'b1, 32'd3, 64'hD, 4'd6);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL e_dup_seen: got %b want 1", got); end
        checks++; if (code !== 8'h03) begin errors++; $display("FAIL e_dup_code: got %h want 03", code); end
        checks++; if (dest !== 4'd6) begin errors++; $display("FAIL e_dup_dest: got %0d want 6", dest); end
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL e_dup_occupancy: got %0d want 1", occupancy); end
        send_msg(1'b0, 32'd0, 64'hD, 4'd0);
        wait_idle();
        send_msg(1'b0, 32'd0, 64'hD, 4'd0);
        wait_idle();
        send_msg(1'b0, 32'd0, 64'hD, 4'd0);
        pop_wake(got, code, dest, lat);
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL e_final_code: got %h want 01", code); end
        checks++; if (dest !== 4'd4) begin errors++; $display("FAIL e_kept_acc_id: got %0d want 4", dest); end
        @(negedge ap_clk);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL e_end_occupancy: got %0d want 0", occupancy); end
`ifdef TW_ERR_STATS_EN
        checks++; if (err_dup_cnt !== 16'd1) begin errors++; $display("FAIL e_err_dup_cnt: got %0d want 1", err_dup_cnt); end
        checks++; if (err_full_cnt !== 16'd0) begin errors++; $display("FAIL e_err_full_cleared: got %0d want 0", err_full_cnt); end
`endif
    endtask

    // Five immediate wakes with the consumer stalled: fifth blocks in UPDATE.
    task automatic test_back_to_back();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        for (int i = 0; i < 4; i++) begin
            send_msg(1'b1, 32'd0, 64'h20 + 64'(i), 4'(7 + i));
            wait_idle();
        end
        send_msg(1'b1, 32'd0, 64'h24, 4'd11);
        repeat (25) @(negedge ap_clk);
        checks++; if (bus.inStream_TREADY !== 1'b0) begin errors++; $display("FAIL f_stall_tready: got %b want 0", bus.inStream_TREADY); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL f_stall_busy: got %b want 1", busy); end
        checks++; if (bus.outStream_TVALID !== 1'b1) begin errors++; $display("FAIL f_stall_tvalid: got %b want 1", bus.outStream_TVALID); end
        for (int i = 0; i < 5; i++) begin
            pop_wake(got, code, dest, lat);
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL f_drain_seen[%0d]: got %b want 1", i, got); end
            checks++; if (code !== 8'h01) begin errors++; $display("FAIL f_drain_code[%0d]: got %h want 01", i, code); end
            checks++; if (dest !== 4'(7 + i)) begin errors++; $display("FAIL f_drain_dest[%0d]: got %0d want %0d", i, dest, 7 + i); end
        end
        wait_idle();
        checks++; if (bus.outStream_TVALID !== 1'b0) begin errors++; $display("FAIL f_drained: got %b want 0", bus.outStream_TVALID); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL f_occupancy: got %0d want 0", occupancy); end
    endtask

    // Reset between beat0 and beat1 clears the table and the partial message.
    task automatic test_reset_mid_message();
        logic got; logic [7:0] code; logic [TID_W-1:0] dest; int lat;
        send_msg(1'b0, 32'd0, 64'h40, 4'd0);
        wait_idle();
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL g_pre_occupancy: got %0d want 1", occupancy); end
        send_beat(hdr(1'b1, 32'd1), 4'd2);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        checks++; if (bus.inStream_TREADY !== 1'b0) begin errors++; $display("FAIL g_rst_tready: got %b want 0", bus.inStream_TREADY); end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL g_rst_occupancy: got %0d want 0", occupancy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL g_rst_busy: got %b want 0", busy); end
        send_msg(1'b1, 32'd0, 64'h30, 4'd9);
        pop_wake(got, code, dest, lat);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL g_fresh_seen: got %b want 1", got); end
        checks++; if (code !== 8'h01) begin errors++; $display("FAIL g_fresh_code: got %h want 01", code); end
        checks++; if (dest !== 4'd9) begin errors++; $display("FAIL g_fresh_dest: got %0d want 9", dest); end
    endtask

    initial begin
        bus.inStream_TDATA   = '0;
        bus.inStream_TVALID  = 1'b0;
        bus.inStream_TID     = '0;
        bus.outStream_TREADY = 1'b0;
        test_reset();
        test_taskwait_then_finish();
        test_finish_first();
        test_zero_comps();
        test_table_full();
        test_duplicate();
        test_back_to_back();
        test_reset_mid_message();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/taskwait_multi.md
Name: taskwait_multi

Overview:
- Parametrised successor of the accelerator taskwait tracker in the OmpSs manager.
- Consumes two-beat taskwait/child-finish messages from accelerators and tracks outstanding child counts per parent task ID in an internal register table.
- Wakes the waiting accelerator through a buffered wakeup queue.
- Adds table-full handling, duplicate-waiter detection and error wakeup codes.

Parameters:
- MAX_ACCS, 16, number of accelerators; TID_W = max(1, clog2(MAX_ACCS)).
- TW_ENTRIES, 16, taskwait table entries, power of two, 2..64.
- CMP_W, 32, component counter width, 8..32.
- WAKE_DEPTH, 4, wakeup FIFO depth, power of two, 2..16.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous active-high reset.
- inStream_TDATA  in  64  beat0 header, beat1 task ID.
- inStream_TVALID  in  1  input valid.
- inStream_TID  in  TID_W  source accelerator, sampled on beat0.
- inStream_TREADY  out  1  input ready.
- outStream_TDATA  out  8  wakeup code.
- outStream_TVALID  out  1  wakeup valid.
- outStream_TREADY  in  1  wakeup ready.
- outStream_TDEST  out  TID_W  accelerator to wake.
- busy  out  1  high when not in READ_HEADER or when the FIFO is non-empty.
- occupancy  out  clog2(TW_ENTRIES)+1  number of valid table entries.

Behaviour:
- Header format: [CMP_W-1:0] components; bit 32 type (1 = taskwait request, 0 = child-finish notification). Other bits ignored.
- Table entry: valid, waiter, acc_id[TID_W], cnt[CMP_W], task_id[64].
- Reset: all entries invalid; FIFO empty; state READ_HEADER.
- Reset output values: TREADY=0 while ap_rst is high; outStream_TVALID=0; busy=0; occupancy=0.
- Reset mid-message discards the partial message.
- FSM:
  - READ_HEADER: TREADY=1. On TVALID, latch components, type and TID; go to READ_TID.
  - READ_TID: TREADY=1. On TVALID, latch task_id; idx=0; go to SCAN.
  - SCAN: examine one entry per cycle.
    - On match (valid && task_id equal), go to UPDATE.
    - Record the lowest-index invalid entry seen.
    - After idx = TW_ENTRIES-1 with no match, go to UPDATE with miss.
  - UPDATE: single cycle; apply the rules below, then go to READ_HEADER. If a wakeup is required and the FIFO is full, stay in UPDATE with no table change until space is available.
  - TREADY=0 in SCAN and UPDATE.
- Base count: the entry's cnt on a hit, 0 on a miss.
- Result arithmetic, modulo 2^CMP_W:
  - type 0: res = base + 1.
  - type 1: res = base - components.
- Hit, type 1, waiter already set: entry unchanged; wake TID with code 8'h03.
- res == 0:
  - Invalidate the entry on a hit; allocate nothing on a miss.
  - Wake code 8'h01. Destination: TID for type 1; the entry's acc_id for type 0 on a hit.
  - type 0 on a miss cannot produce res == 0.
- res != 0:
  - Write cnt=res and valid=1 (hit, or allocate the free entry).
  - type 1 also sets waiter=1 and acc_id=TID.
  - type 0 leaves waiter and acc_id unchanged; on a fresh allocation waiter=0.
- Miss with no free entry and res != 0:
  - type 1: no table change; wake TID with code 8'h02.
  - type 0: message dropped silently.
- Latency: for a match at index k, SCAN lasts k+1 cycles and UPDATE 1 cycle. outStream_TVALID rises in the cycle after UPDATE when the FIFO was empty. A miss takes TW_ENTRIES SCAN cycles.
- Wakeup FIFO:
  - AXI-Stream semantics; TDATA and TDEST stable while TVALID && !TREADY.
  - Simultaneous push and pop when full is permitted and does not stall.
- occupancy updates in the cycle after UPDATE.

Optional Feature:
- Macro TW_ERR_STATS_EN.
- Defined: adds output ports err_full_cnt[15:0], err_dup_cnt[15:0] and drop_cnt[15:0], all saturating and cleared by ap_rst.
  - err_full_cnt increments on each code 8'h02 push.
  - err_dup_cnt increments on each code 8'h03 push.
  - drop_cnt increments on each dropped type-0 message.
- Undefined: ports absent; all other behaviour identical.

Test Plan:
- Send type1 comps=2 id=0xA from TID 3, then two type0 id=0xA -> exactly one wakeup, TDEST=3, TDATA=8'h01, after the second notification; occupancy returns to 0.
- Send type0 id=0xB twice, then type1 comps=2 id=0xB from TID 5 -> immediate wakeup TDEST=5, code 8'h01; entry invalidated.
- Send type1 comps=0 id=0xC from TID 1 -> wakeup TDEST=1, code 8'h01; occupancy stays 0.
- Fill all 16 entries with distinct ids (type0), then type1 comps=4 id=0x99 from TID 2 -> code 8'h02, TDEST 2; then type0 id=0x98 -> no output; drop_cnt=1 when TW_ERR_STATS_EN is defined.
- Send type1 id=0xD twice (comps 3) from TIDs 4 then 6 -> second gets code 8'h03, TDEST 6; entry keeps acc_id 4.
- Hold outStream_TREADY=0 and complete 5 taskwaits -> 4 queued; fifth message stalls in UPDATE with TREADY low; release TREADY -> all 5 delivered in order with no loss.
- Assert ap_rst between beat0 and beat1 -> table empty, next message parsed as a fresh header.
